uart_tx_fifo: RTL

Parametrised serial transmitter, the successor to the fixed 8N1/115200 TX chip.
- Buffers bytes in an internal FIFO and transmits them back-to-back on the TX line.
- Frame format is configurable: data width, parity and stop bits.
- Keeps the memory-mapped load/in/out style so it plugs into the same I/O bus; out reports buffer and line status.

---
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered serial transmitter with a configurable frame.
// Bytes queue in a small FIFO and leave back-to-back on TX.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] in,
   output logic        TX,
   output logic [15:0] out
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PAR, STOP
   } state_t;

   state_t               state, state_n;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wp, rp;
   logic [CW-1:0]        count, count_n;
   logic [BW-1:0]        tick;
   logic [3:0]           nbit, nbit_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic                 parity, par_n;
   logic                 ovf, ovf_n;
   logic                 tx_n;
   logic                 push, pop, bit_end;
   logic                 full, cmd, wr;
   logic [15:0]          out_n;
   logic                 unused_in;

   assign unused_in = ^in[14:DATA_BITS];

   assign cmd     = load & in[15];
   assign wr      = load & ~in[15];
   assign full    = (count == CW'(FIFO_DEPTH));
   assign push    = wr & ~full;
   assign bit_end = (tick == BW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      shift_n = shift;
      nbit_n  = nbit;
      par_n   = parity;
      tx_n    = 1'b1;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               nbit_n  = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_n = shift >> 1;
               if (nbit == 4'(DATA_BITS - 1)) begin
                  nbit_n  = '0;
                  state_n = (PARITY != 0) ? PAR : STOP;
               end else begin
                  nbit_n = nbit + 4'd1;
               end
            end
         end
         PAR: begin
            if (bit_end) begin
               state_n = STOP;
               nbit_n  = '0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (nbit == 4'(STOP_BITS - 1)) begin
                  if (count != '0) begin
                     pop     = 1'b1;
                     state_n = START;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  nbit_n = nbit + 4'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // A pop always starts a fresh frame with a freshly computed parity
      if (pop) begin
         shift_n = mem[rp];
         par_n   = (^mem[rp]) ^ (PARITY == 1);
         nbit_n  = '0;
      end
      unique case (state_n)
         IDLE:    tx_n = 1'b1;
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         PAR:     tx_n = par_n;
         STOP:    tx_n = 1'b1;
         default: tx_n = 1'b1;
      endcase
   end

   always_comb begin
      count_n = count + CW'(push) - CW'(pop);
      ovf_n   = ovf;
      if (cmd)
         ovf_n = 1'b0;
      else if (wr && full)
         ovf_n = 1'b1;
      out_n = {count_n == CW'(FIFO_DEPTH),
               (state_n != IDLE) || (count_n != '0),
               ovf_n,
               count_n == '0,
               7'b0,
               5'(count_n)};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         wp     <= '0;
         rp     <= '0;
         count  <= '0;
         tick   <= '0;
         nbit   <= '0;
         shift  <= '0;
         parity <= 1'b0;
         ovf    <= 1'b0;
         TX     <= 1'b1;
         out    <= 16'h1000;
      end else begin
         state  <= state_n;
         count  <= count_n;
         nbit   <= nbit_n;
         shift  <= shift_n;
         parity <= par_n;
         ovf    <= ovf_n;
         TX     <= tx_n;
         out    <= out_n;
         if (push)
            wp <= wp + AW'(1);
         if (pop)
            rp <= rp + AW'(1);
         if (state == IDLE || bit_end)
            tick <= '0;
         else
            tick <= tick + BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wp] <= in[DATA_BITS-1:0];
   end

endmodule
